// File: rtl/tri_scan_sequencer.sv
// tri_scan_sequencer: walks all 120 map triangle candidates for one pixel
// request in painter's order. For each candidate it reads the four corner
// heights, presents the descriptor to the feasibility unit, and keeps the
// last feasible candidate as the pixel response.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is high only in IDLE. resp_valid stays high, with
// resp_* held stable, until the edge where resp_ready is also high.
module tri_scan_sequencer #(
   parameter int HEIGHT_W = 8,
   parameter int MAP_BITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [9:0]            req_xpos,
   input  logic [9:0]            req_ypos,
   input  logic                  req_side,
   output logic [2*MAP_BITS-1:0] ram_addr,
   input  logic [HEIGHT_W-1:0]   ram_rdata,
   output logic [9:0]            tri_xpos,
   output logic [9:0]            tri_ypos,
   output logic                  tri_side,
   output logic [4:0]            tri_line,
   output logic [3:0]            tri_i,
   output logic [MAP_BITS-1:0]   tri_mapx,
   output logic [MAP_BITS-1:0]   tri_mapy,
   output logic [HEIGHT_W-1:0]   tri_ah,
   output logic [HEIGHT_W-1:0]   tri_bh,
   output logic [HEIGHT_W-1:0]   tri_ch,
   output logic [HEIGHT_W-1:0]   tri_dh,
   input  logic                  tri_feasible,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic                  resp_hit,
   output logic [4:0]            resp_line,
   output logic [3:0]            resp_i,
   output logic [HEIGHT_W-1:0]   resp_ah,
   output logic [2:0]            dbg_state
);

   typedef enum logic [2:0] {
      IDLE = 3'd0, RA = 3'd1, RB = 3'd2, RC = 3'd3,
      RD = 3'd4, RW = 3'd5, EV = 3'd6, DONE = 3'd7
   } state_t;

   state_t state_q, state_d;
   logic [9:0] xpos_q, xpos_d, ypos_q, ypos_d;
   logic side_q, side_d;
   logic [4:0] line_q, line_d;
   logic [3:0] i_q, i_d;
   logic [MAP_BITS-1:0] mapx_q, mapx_d, mapy_q, mapy_d;
   logic [HEIGHT_W-1:0] ah_q, ah_d, bh_q, bh_d, ch_q, ch_d, dh_q, dh_d;
   logic resp_valid_q, resp_valid_d, hit_q, hit_d;
   logic [4:0] rline_q, rline_d;
   logic [3:0] ri_q, ri_d;
   logic [HEIGHT_W-1:0] rah_q, rah_d;
   logic [MAP_BITS-1:0] mapx_m1, mapy_m1;

   assign mapx_m1 = mapx_q - 1'b1;
   assign mapy_m1 = mapy_q - 1'b1;

   // Corner read address; x-1 / y-1 wrap, the wrapped data is masked on capture.
   always_comb begin
      ram_addr = '0;
      case (state_q)
         RA:      ram_addr = {mapx_q, mapy_q};
         RB:      ram_addr = {mapx_q, mapy_m1};
         RC:      ram_addr = {mapx_m1, mapy_m1};
         RD:      ram_addr = {mapx_m1, mapy_q};
         default: ram_addr = '0;
      endcase
   end

   // Next-state, candidate stepping, corner capture and hit tracking.
   always_comb begin
      state_d      = state_q;
      xpos_d       = xpos_q;
      ypos_d       = ypos_q;
      side_d       = side_q;
      line_d       = line_q;
      i_d          = i_q;
      ah_d         = ah_q;
      bh_d         = bh_q;
      ch_d         = ch_q;
      dh_d         = dh_q;
      resp_valid_d = 1'b0;
      hit_d        = hit_q;
      rline_d      = rline_q;
      ri_d         = ri_q;
      rah_d        = rah_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               xpos_d  = req_xpos;
               ypos_d  = req_ypos;
               side_d  = req_side;
               line_d  = 5'd1;
               i_d     = 4'd0;
               hit_d   = 1'b0;
               rline_d = '0;
               ri_d    = '0;
               rah_d   = '0;
               state_d = RA;
            end
         end
         RA: state_d = RB;
         RB: begin
            ah_d    = ram_rdata;
            state_d = RC;
         end
         RC: begin
            bh_d    = (mapy_q == '0) ? '0 : ram_rdata;
            state_d = RD;
         end
         RD: begin
            ch_d    = (mapx_q == '0 || mapy_q == '0) ? '0 : ram_rdata;
            state_d = RW;
         end
         RW: begin
            dh_d    = (mapx_q == '0) ? '0 : ram_rdata;
            state_d = EV;
         end
         EV: begin
            if (tri_feasible) begin
               hit_d   = 1'b1;
               rline_d = line_q;
               ri_d    = i_q;
               rah_d   = ah_q;
            end
            if ({1'b0, i_q} == (5'd15 - line_q)) begin
               if (line_q == 5'd15) begin
                  state_d = DONE;
               end else begin
                  line_d  = line_q + 5'd1;
                  i_d     = 4'd0;
                  state_d = RA;
               end
            end else begin
               i_d     = i_q + 4'd1;
               state_d = RA;
            end
         end
         DONE: begin
            if (resp_valid_q && resp_ready) begin
               state_d = IDLE;
            end else begin
               resp_valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Map coordinates follow the candidate counters, so they move on RA entry.
      mapx_d = line_d[MAP_BITS-1:0] + i_d;
      mapy_d = i_d;
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         xpos_q       <= '0;
         ypos_q       <= '0;
         side_q       <= 1'b0;
         line_q       <= '0;
         i_q          <= '0;
         mapx_q       <= '0;
         mapy_q       <= '0;
         ah_q         <= '0;
         bh_q         <= '0;
         ch_q         <= '0;
         dh_q         <= '0;
         resp_valid_q <= 1'b0;
         hit_q        <= 1'b0;
         rline_q      <= '0;
         ri_q         <= '0;
         rah_q        <= '0;
      end else begin
         state_q      <= state_d;
         xpos_q       <= xpos_d;
         ypos_q       <= ypos_d;
         side_q       <= side_d;
         line_q       <= line_d;
         i_q          <= i_d;
         mapx_q       <= mapx_d;
         mapy_q       <= mapy_d;
         ah_q         <= ah_d;
         bh_q         <= bh_d;
         ch_q         <= ch_d;
         dh_q         <= dh_d;
         resp_valid_q <= resp_valid_d;
         hit_q        <= hit_d;
         rline_q      <= rline_d;
         ri_q         <= ri_d;
         rah_q        <= rah_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign dbg_state  = state_q;
   assign tri_xpos   = xpos_q;
   assign tri_ypos   = ypos_q;
   assign tri_side   = side_q;
   assign tri_line   = line_q;
   assign tri_i      = i_q;
   assign tri_mapx   = mapx_q;
   assign tri_mapy   = mapy_q;
   assign tri_ah     = ah_q;
   assign tri_bh     = bh_q;
   assign tri_ch     = ch_q;
   assign tri_dh     = dh_q;
   assign resp_valid = resp_valid_q;
   assign resp_hit   = hit_q;
   assign resp_line  = rline_q;
   assign resp_i     = ri_q;
   assign resp_ah    = rah_q;

endmodule

// File: tb/tb_tri_scan_sequencer.sv
// Directed bench for tri_scan_sequencer: synchronous RAM model, a feasibility
// stub matching a small list of (line, i) pairs, and a probe that records the
// descriptor seen during one chosen candidate's EV cycle.
module tb_tri_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [9:0] req_xpos = '0;
   logic [9:0] req_ypos = '0;
   logic       req_side = 1'b0;
   logic [7:0] ram_addr;
   logic [7:0] ram_rdata = '0;
   logic [9:0] tri_xpos, tri_ypos;
   logic       tri_side;
   logic [4:0] tri_line;
   logic [3:0] tri_i, tri_mapx, tri_mapy;
   logic [7:0] tri_ah, tri_bh, tri_ch, tri_dh;
   logic       tri_feasible;
   logic       resp_valid;
   logic       resp_ready = 1'b0;
   logic       resp_hit;
   logic [4:0] resp_line;
   logic [3:0] resp_i;
   logic [7:0] resp_ah;
   logic [2:0] dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   // clock / reset block
   always #5 clk = ~clk;

   tri_scan_sequencer dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_xpos(req_xpos), .req_ypos(req_ypos), .req_side(req_side),
      .ram_addr(ram_addr), .ram_rdata(ram_rdata),
      .tri_xpos(tri_xpos), .tri_ypos(tri_ypos), .tri_side(tri_side),
      .tri_line(tri_line), .tri_i(tri_i),
      .tri_mapx(tri_mapx), .tri_mapy(tri_mapy),
      .tri_ah(tri_ah), .tri_bh(tri_bh), .tri_ch(tri_ch), .tri_dh(tri_dh),
      .tri_feasible(tri_feasible),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_hit(resp_hit), .resp_line(resp_line), .resp_i(resp_i),
      .resp_ah(resp_ah), .dbg_state(dbg_state)
   );

   // height RAM model, one-cycle read latency
   logic [7:0] mem [256];
   always @(posedge clk) ram_rdata <= mem[ram_addr];

   // feasibility stub
   int         n_hits = 0;
   logic [4:0] hit_line [2];
   logic [3:0] hit_i [2];
   always_comb begin
      tri_feasible = 1'b0;
      for (int k = 0; k < 2; k++)
         if (k < n_hits && tri_line == hit_line[k] && tri_i == hit_i[k])
            tri_feasible = 1'b1;
   end

   // EV-cycle probe
   logic [4:0] probe_line = '0;
   logic [3:0] probe_i = '0;
   logic       probe_seen = 1'b0;
   logic [3:0] p_mapx, p_mapy;
   logic [7:0] p_ah, p_bh, p_ch, p_dh;
   always @(negedge clk) begin
      if (dbg_state == 3'd6 && tri_line == probe_line && tri_i == probe_i) begin
         probe_seen <= 1'b1;
         p_mapx <= tri_mapx; p_mapy <= tri_mapy;
         p_ah <= tri_ah; p_bh <= tri_bh; p_ch <= tri_ch; p_dh <= tri_dh;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic fill_mem(input int mode);
      for (int a = 0; a < 256; a++)
         mem[a] = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : 8'(a);
   endtask

   // driver: accept one request, count edges from accept until resp_valid
   task automatic run_req(input logic [9:0] x, input logic [9:0] y, input logic s,
                          output int cycles);
      @(negedge clk);
      check("req_ready_before_req", req_ready, 1);
      req_xpos = x; req_ypos = y; req_side = s; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      cycles = 0;
      while (!resp_valid && cycles < 2000) begin
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic handshake();
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("resp_valid_after_hs", resp_valid, 0);
      check("req_ready_after_hs", req_ready, 1);
   endtask

   int cyc;
   logic [4:0] s_line;
   logic [3:0] s_i;
   logic [7:0] s_ah;
   logic       s_hit;

   initial begin
      fill_mem(0);
      repeat (3) @(posedge clk);
      #1;
      // 1. reset values
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_tri_line", tri_line, 0);
      check("rst_tri_ah", tri_ah, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_tri_xpos", tri_xpos, 0);
      @(negedge clk); rst = 1'b0;

      // mid-scan reset
      @(negedge clk);
      req_xpos = 10'd7; req_ypos = 10'd9; req_valid = 1'b1;
      @(posedge clk); #1; req_valid = 1'b0;
      repeat (50) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("midrst_state", dbg_state, 0);
      check("midrst_req_ready", req_ready, 1);
      check("midrst_tri_line", tri_line, 0);
      check("midrst_tri_xpos", tri_xpos, 0);
      @(negedge clk); rst = 1'b0;
      repeat (800) @(posedge clk);
      #1;
      check("midrst_no_resp", resp_valid, 0);

      // 2. no feasible candidates
      n_hits = 0;
      run_req(10'd320, 10'd240, 1'b0, cyc);
      check("t2_latency", cyc, 721);
      check("t2_hit", resp_hit, 0);
      check("t2_xpos", tri_xpos, 320);
      check("t2_ypos", tri_ypos, 240);
      check("t2_side", tri_side, 0);
      handshake();

      // 3. single hit at (3,2), H[5][2] = 0x40
      mem[8'h52] = 8'h40;
      n_hits = 1; hit_line[0] = 5'd3; hit_i[0] = 4'd2;
      probe_line = 5'd3; probe_i = 4'd2; probe_seen = 1'b0;
      run_req(10'd100, 10'd50, 1'b1, cyc);
      check("t3_latency", cyc, 721);
      check("t3_hit", resp_hit, 1);
      check("t3_line", resp_line, 3);
      check("t3_i", resp_i, 2);
      check("t3_ah", resp_ah, 8'h40);
      check("t3_probe_seen", probe_seen, 1);
      check("t3_mapx", p_mapx, 5);
      check("t3_mapy", p_mapy, 2);
      check("t3_side", tri_side, 1);
      handshake();

      // 4. two hits, last in scan order wins; mem[a] = a
      fill_mem(2);
      n_hits = 2; hit_line[0] = 5'd1; hit_i[0] = 4'd0; hit_line[1] = 5'd14; hit_i[1] = 4'd1;
      run_req(10'd1, 10'd2, 1'b0, cyc);
      check("t4_hit", resp_hit, 1);
      check("t4_line", resp_line, 14);
      check("t4_i", resp_i, 1);
      check("t4_ah", resp_ah, 8'hF1);
      handshake();

      // 5. masked corners on (1,0), RAM all 0xFF; then 6. held response
      fill_mem(1);
      n_hits = 1; hit_line[0] = 5'd15; hit_i[0] = 4'd0;
      probe_line = 5'd1; probe_i = 4'd0; probe_seen = 1'b0;
      run_req(10'd640, 10'd480, 1'b1, cyc);
      check("t5_probe_seen", probe_seen, 1);
      check("t5_ah", p_ah, 8'hFF);
      check("t5_bh", p_bh, 8'h00);
      check("t5_ch", p_ch, 8'h00);
      check("t5_dh", p_dh, 8'hFF);
      check("t5_line", resp_line, 15);
      s_hit = resp_hit; s_line = resp_line; s_i = resp_i; s_ah = resp_ah;
      check("t6_hit_first", s_hit, 1);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         check("t6_hold_valid", resp_valid, 1);
         check("t6_hold_req_ready", req_ready, 0);
         check("t6_hold_line", resp_line, s_line);
         check("t6_hold_i", resp_i, s_i);
         check("t6_hold_ah", resp_ah, s_ah);
      end
      @(negedge clk); resp_ready = 1'b1;
      @(posedge clk); #1;
      check("t6_hs_valid", resp_valid, 0);
      @(negedge clk);
      resp_ready = 1'b0;
      req_xpos = 10'd33; req_ypos = 10'd44; req_side = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("t6_new_accept_state", dbg_state, 1);
      check("t6_new_xpos", tri_xpos, 33);
      check("t6_new_line", tri_line, 1);
      check("t6_new_hit_clear", resp_hit, 0);

      @(negedge clk); rst = 1'b1;
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tri_scan_sequencer.md
Name: tri_scan_sequencer

Overview:
- Driver side of the triangle-feasibility interface. It takes one screen pixel request (xpos, ypos, screen side) and walks every map triangle candidate in painter's order.
- For each candidate it fetches the four corner heights from the height-map RAM and presents a complete triangle descriptor to the combinational feasibility unit, then samples the unit's feasible answer.
- It returns the last (front-most) hit for the pixel to the pixel/framebuffer writer.

Parameters:
- HEIGHT_W, 8, height sample width; equals the feasibility unit height input width.
- MAP_BITS, 4, map coordinate width; the map is 16x16 and the RAM address is {x, y}, 2*MAP_BITS bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  pixel request valid
- req_ready  out  1  high only in IDLE
- req_xpos  in  10  pixel x
- req_ypos  in  10  pixel y
- req_side  in  1  0 = left half-triangle, 1 = right half-triangle
- ram_addr  out  8  height RAM read address {x, y}
- ram_rdata  in  HEIGHT_W  height RAM data, valid 1 cycle after ram_addr
- tri_xpos, tri_ypos  out  10 each  registered copy of the request pixel
- tri_side  out  1  registered req_side
- tri_line  out  5  candidate line, 1..15
- tri_i  out  4  candidate index, 0..15-line
- tri_mapx, tri_mapy  out  4 each  corner-a map coordinates
- tri_ah, tri_bh, tri_ch, tri_dh  out  HEIGHT_W each  corner heights
- tri_feasible  in  1  combinational answer from the feasibility unit
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts the result
- resp_hit  out  1  at least one candidate was feasible
- resp_line  out  5  line of the last feasible candidate
- resp_i  out  4  index of the last feasible candidate
- resp_ah  out  HEIGHT_W  corner-a height of the last hit, used for shading

Behaviour:
- Reset values:
  - FSM in IDLE; req_ready=1.
  - resp_valid=0, resp_hit=0, resp_line=0, resp_i=0, resp_ah=0.
  - All tri_* outputs = 0; ram_addr=0.
- Candidate order: line L from 1 to 15 (outer loop), i from 0 to 15-L (inner loop). That gives 120 candidates.
- Candidate coordinates: tri_mapx = L+i and tri_mapy = i.
- Corner addresses:
  - a = (x, y)
  - b = (x, y-1)
  - c = (x-1, y-1)
  - d = (x-1, y)
- If a corner coordinate would be -1, the address is still issued (wrapped), but the captured height is forced to 0.
- States and transitions:
  - IDLE: on req_valid, capture the request into tri_xpos/tri_ypos/tri_side; set L=1, i=0; clear the hit registers; go to RA.
  - RA: issue the a address.
  - RB: issue the b address; capture a.
  - RC: issue the c address; capture b.
  - RD: issue the d address; capture c.
  - RW: capture d.
  - EV: tri_* outputs are stable; sample tri_feasible.
    - If it is 1, update resp_line, resp_i and resp_ah; set resp_hit.
    - Advance to the next candidate and go to RA, or go to DONE after candidate (15, 0).
  - DONE: resp_valid=1, and the resp_* outputs stay stable until resp_valid & resp_ready; then go to IDLE.
- Timing:
  - Each candidate takes exactly 6 cycles.
  - resp_valid rises exactly 721 cycles after the request-accept edge.
  - tri_line, tri_i, tri_mapx and tri_mapy update on entry to RA and are constant through EV.
  - tri_ah..dh update as they are captured and are all final in EV.
- Tie rule: a later candidate overwrites an earlier hit; the last feasible candidate in scan order wins.
- Back-to-back operation:
  - req_ready=0 in every state except IDLE, so requests are not queued.
  - A request can be accepted in the cycle after the DONE handshake.
- Reset asserted mid-scan: immediate return to IDLE with all outputs at their reset values. No response is produced for the aborted request.
- Width rules:
  - L+i never exceeds 15, so there is no map-coordinate wrap.
  - The x-1 and y-1 addresses wrap modulo 16 but are masked as described above.

Test Plan:
1. After reset: req_ready=1, resp_valid=0, all tri_*=0. Assert rst for 3 cycles mid-scan -> back in IDLE, resp_valid stays 0.
2. RAM all 0x00, stub drives tri_feasible=0 always, request (320, 240, 0) -> resp_valid rises at accept+721 with resp_hit=0.
3. Stub asserts feasible only when tri_line=3 and tri_i=2; RAM holds H[5][2]=0x40 -> resp_hit=1, resp_line=3, resp_i=2, resp_ah=0x40; tri_mapx=5 and tri_mapy=2 during that EV.
4. Stub asserts feasible for (1,0) and (14,1) -> resp_line=14, resp_i=1 (last hit wins).
5. Candidate (1,0): RAM data 0xFF at every address -> tri_ah=0xFF, tri_bh=0, tri_ch=0, tri_dh=0xFF (masked y-1 corners).
6. Hold resp_ready=0 for 10 cycles after DONE -> resp_* stable and req_ready=0; then pulse resp_ready -> a new request is accepted on the next cycle.
